// File: rtl/regfile_banked_if.sv
// Read/write bus of the banked register file: NREAD registered read ports,
// one write port and the ready flag raised once the power-on clear sweep finishes.
interface regfile_banked_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NBANKS = 2,
    parameter int NREAD  = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    logic                    ready;
    logic [NREAD*BW-1:0]     readBank;
    logic [NREAD*AW-1:0]     readAddr;
    logic [NREAD*XLEN-1:0]   readData;
    logic                    writeEnable;
    logic [BW-1:0]           writeBank;
    logic [AW-1:0]           writeAddr;
    logic [XLEN-1:0]         writeData;

    modport master (
        input  ready, readData,
        output readBank, readAddr, writeEnable, writeBank, writeAddr, writeData
    );

    modport slave (
        output ready, readData,
        input  readBank, readAddr, writeEnable, writeBank, writeAddr, writeData
    );
endinterface

// File: rtl/regfile_banked.sv
// Multi-bank, multi-read-port register file with write-to-read forwarding
// and a post-reset clear sweep that zeroes every entry before ready rises.
module regfile_banked #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NBANKS = 2,
    parameter int NREAD  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    regfile_banked_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_reg, state_next;
    logic [AW:0]     sweep_idx_reg, sweep_idx_next;
    logic [XLEN-1:0] mem [NBANKS][NREGS];
    logic            wr_legal;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= CLEAR;
            sweep_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
        end
    end

    // The counter is one bit wider than an address so non-power-of-two NREGS still terminates.
    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        if (state_reg == CLEAR) begin
            sweep_idx_next = sweep_idx_reg + {{AW{1'b0}}, 1'b1};
            if (sweep_idx_reg == (AW+1)'(NREGS - 1)) begin
                state_next = RUN;
            end
        end
    end

    assign bus.ready = (state_reg == RUN);

    // Bank 0 entry 0 is the hard-wired zero register; out-of-range targets are dropped.
    assign wr_legal = bus.writeEnable && (state_reg == RUN)
                   && (32'(bus.writeBank) < NBANKS)
                   && (32'(bus.writeAddr) < NREGS)
                   && !((bus.writeBank == '0) && (bus.writeAddr == '0));

    // A reset landing in RUN forces CLEAR asynchronously, so a write in that cycle never lands.
    always_ff @(posedge CLK) begin
        if (state_reg == CLEAR) begin
            for (int b = 0; b < NBANKS; b++) begin
                mem[b][sweep_idx_reg[AW-1:0]] <= '0;
            end
        end else if (wr_legal) begin
            mem[bus.writeBank][bus.writeAddr] <= bus.writeData;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
        logic [BW-1:0]   bank;
        logic [AW-1:0]   addr;
        logic            legal;
        logic            is_zero;
        logic            fwd;
        logic [XLEN-1:0] data_reg, data_next;

        assign bank    = bus.readBank[gi*BW +: BW];
        assign addr    = bus.readAddr[gi*AW +: AW];
        assign legal   = (32'(bank) < NBANKS) && (32'(addr) < NREGS);
        assign is_zero = (bank == '0) && (addr == '0);
        assign fwd     = wr_legal && (bank == bus.writeBank) && (addr == bus.writeAddr);

        always_comb begin
            data_next = '0;
            if (legal && !is_zero) begin
                data_next = fwd ? bus.writeData : mem[bank][addr];
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                data_reg <= '0;
            end else if (state_reg == RUN) begin
                data_reg <= data_next;
            end else begin
                data_reg <= '0;
            end
        end

        assign bus.readData[gi*XLEN +: XLEN] = data_reg;
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench: default 32x2x2 instance plus an odd 24x3x3 instance for
// illegal-target and non-power-of-two sweep checks.
module tb_regfile_banked;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic rst_odd = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    regfile_banked_if #(.XLEN(32), .NREGS(32), .NBANKS(2), .NREAD(2)) bus ();
    regfile_banked_if #(.XLEN(32), .NREGS(24), .NBANKS(3), .NREAD(3)) obus ();

    regfile_banked #(.XLEN(32), .NREGS(32), .NBANKS(2), .NREAD(2)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    regfile_banked #(.XLEN(32), .NREGS(24), .NBANKS(3), .NREAD(3)) dut_odd (
        .CLK(CLK), .RESET(rst_odd), .bus(obus)
    );

    typedef struct {
        int we, wb, wa; logic [31:0] wd;
        int rb0, ra0, rb1, ra1;
        logic [31:0] e0, e1;
    } vec_t;

    typedef struct {
        int we, wb, wa; logic [31:0] wd;
        int rb0, ra0, rb1, ra1, rb2, ra2;
        logic [31:0] e0, e1, e2;
    } ovec_t;

    vec_t  vecs [11];
    ovec_t ovecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int p);
        return bus.readData[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rdo(input int p);
        return obus.readData[p*32 +: 32];
    endfunction

    // Reset pulse then full sweep; optionally re-reset after n_pre edges of the sweep.
    // A write to x3 is held throughout and must be ignored.
    task automatic sweep(input int n_pre);
        bus.writeEnable = 1'b1; bus.writeBank = 1'b0; bus.writeAddr = 5'd3;
        bus.writeData = 32'h55; bus.readBank = 2'b00; bus.readAddr = {5'd3, 5'd3};
        @(posedge CLK); #1;
        RESET = 1'b1; #2;
        check("rst_ready", {31'b0, bus.ready}, 32'd0);
        check("rst_rd0", rd(0), 32'd0);
        check("rst_rd1", rd(1), 32'd0);
        RESET = 1'b0;
        if (n_pre > 0) begin
            repeat (n_pre) @(posedge CLK);
            #1;
            check("mid_ready", {31'b0, bus.ready}, 32'd0);
            RESET = 1'b1; #2;
            RESET = 1'b0;
        end
        for (int e = 1; e <= 32; e++) begin
            @(posedge CLK); #1;
            check($sformatf("sweep_ready_e%0d", e), {31'b0, bus.ready}, (e == 32) ? 32'd1 : 32'd0);
            check($sformatf("sweep_rd0_e%0d", e), rd(0), 32'd0);
        end
        bus.writeEnable = 1'b0;
    endtask

    task automatic step(input vec_t v, input int idx);
        bus.writeEnable = v.we[0];
        bus.writeBank   = 1'(v.wb);
        bus.writeAddr   = 5'(v.wa);
        bus.writeData   = v.wd;
        bus.readBank    = {1'(v.rb1), 1'(v.rb0)};
        bus.readAddr    = {5'(v.ra1), 5'(v.ra0)};
        @(posedge CLK); #1;
        $display("vec %0d: we=%0d w(%0d,%0d)=%08h r0(%0d,%0d)=%08h r1(%0d,%0d)=%08h",
                 idx, v.we, v.wb, v.wa, v.wd, v.rb0, v.ra0, rd(0), v.rb1, v.ra1, rd(1));
        check($sformatf("vec%0d_p0", idx), rd(0), v.e0);
        check($sformatf("vec%0d_p1", idx), rd(1), v.e1);
    endtask

    task automatic ostep(input ovec_t v, input int idx);
        obus.writeEnable = v.we[0];
        obus.writeBank   = 2'(v.wb);
        obus.writeAddr   = 5'(v.wa);
        obus.writeData   = v.wd;
        obus.readBank    = {2'(v.rb2), 2'(v.rb1), 2'(v.rb0)};
        obus.readAddr    = {5'(v.ra2), 5'(v.ra1), 5'(v.ra0)};
        @(posedge CLK); #1;
        $display("ovec %0d: we=%0d w(%0d,%0d)=%08h rd=%08h %08h %08h",
                 idx, v.we, v.wb, v.wa, v.wd, rdo(0), rdo(1), rdo(2));
        check($sformatf("ovec%0d_p0", idx), rdo(0), v.e0);
        check($sformatf("ovec%0d_p1", idx), rdo(1), v.e1);
        check($sformatf("ovec%0d_p2", idx), rdo(2), v.e2);
    endtask

    initial begin
        //          we wb wa wd            rb0 ra0 rb1 ra1  e0            e1
        vecs[0]  = '{1, 0, 5, 32'hDEADBEEF, 1, 5, 0, 6,  32'h0,        32'h0};
        vecs[1]  = '{1, 1, 5, 32'h12345678, 0, 5, 0, 0,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{0, 0, 0, 32'h0,        0, 5, 1, 5,  32'hDEADBEEF, 32'h12345678};
        vecs[3]  = '{1, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0,  32'h0,        32'h0};
        vecs[4]  = '{1, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0,  32'h0,        32'hFFFFFFFF};
        vecs[5]  = '{0, 0, 0, 32'h0,        0, 0, 1, 0,  32'h0,        32'hFFFFFFFF};
        vecs[6]  = '{1, 0, 7, 32'hA5A5A5A5, 0, 7, 1, 7,  32'hA5A5A5A5, 32'h0};
        vecs[7]  = '{0, 0, 0, 32'h0,        1, 7, 0, 7,  32'h0,        32'hA5A5A5A5};
        vecs[8]  = '{0, 0, 0, 32'h0,        0, 5, 0, 5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{1, 1, 31, 32'hCAFEF00D, 1, 31, 0, 31, 32'hCAFEF00D, 32'h0};
        vecs[10] = '{0, 0, 0, 32'h0,        0, 3, 1, 31, 32'h0,        32'hCAFEF00D};

        //          we wb wa  wd      rb0 ra0 rb1 ra1 rb2 ra2  e0     e1     e2
        ovecs[0] = '{1, 3, 1,  32'h11, 3, 1,  2, 23, 2, 24, 32'h0,  32'h0,  32'h0};
        ovecs[1] = '{1, 2, 24, 32'h22, 2, 24, 3, 1,  1, 0,  32'h0,  32'h0,  32'h0};
        ovecs[2] = '{1, 2, 23, 32'h33, 2, 23, 2, 23, 0, 23, 32'h33, 32'h33, 32'h0};
        ovecs[3] = '{0, 0, 0,  32'h0,  2, 23, 3, 23, 2, 24, 32'h33, 32'h0,  32'h0};

        bus.writeEnable = 1'b0; bus.writeBank = '0; bus.writeAddr = '0; bus.writeData = '0;
        bus.readBank = '0; bus.readAddr = '0;
        obus.writeEnable = 1'b0; obus.writeBank = '0; obus.writeAddr = '0; obus.writeData = '0;
        obus.readBank = '0; obus.readAddr = '0;
        #2 rst_odd = 1'b1;

        sweep(0);

        // Every entry of both banks must read zero after the sweep.
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 32; a++) begin
                bus.readBank = {1'(b), 1'(b)};
                bus.readAddr = {5'(31 - a), 5'(a)};
                @(posedge CLK); #1;
                check($sformatf("zero_b%0d_a%0d", b, a), rd(0), 32'd0);
                check($sformatf("zero_b%0d_a%0d", b, 31 - a), rd(1), 32'd0);
            end
        end
        $display("zero scan of 64 entries done");

        for (int i = 0; i < 11; i++) step(vecs[i], i);

        // Reset from RUN (readData nonzero), then re-reset at sweep edge 10.
        bus.writeEnable = 1'b1; bus.writeBank = 1'b0; bus.writeAddr = 5'd9; bus.writeData = 32'h99;
        sweep(10);
        bus.readBank = 2'b10; bus.readAddr = {5'd5, 5'd5};
        @(posedge CLK); #1;
        $display("post-reclear: x5=%08h f5=%08h", rd(0), rd(1));
        check("reclear_x5", rd(0), 32'd0);
        check("reclear_f5", rd(1), 32'd0);
        bus.readBank = 2'b00; bus.readAddr = {5'd9, 5'd7};
        @(posedge CLK); #1;
        $display("post-reclear: x7=%08h x9=%08h", rd(0), rd(1));
        check("reclear_x7", rd(0), 32'd0);
        check("reclear_x9", rd(1), 32'd0);

        // Odd instance: 24-entry sweep, illegal bank/address handling.
        @(posedge CLK); #1;
        rst_odd = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge CLK); #1;
            check($sformatf("osweep_ready_e%0d", e), {31'b0, obus.ready}, (e == 24) ? 32'd1 : 32'd0);
        end
        $display("odd sweep: ready=%0d after 24 edges", obus.ready);
        for (int i = 0; i < 4; i++) ostep(ovecs[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_banked.md
# regfile_banked

Parametrised multi-bank, multi-read-port register file for the multi-cycle RV32 core, replacing the single-bank, fixed two-read-port integer register bank. It holds NBANKS banks of NREGS registers (bank 0 = integer, bank 1 = floating-point), serves NREAD registered read ports and one write port, and forwards same-cycle writes to reads. After every reset it runs a hardware clear sweep that zeroes all entries and holds `ready` low until the sweep completes. It sits between the core's decode stage (reads) and writeback stage (write).

## Interface
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: registers per bank, ≥2; `AW = $clog2(NREGS)`.
- `NBANKS`, 2: number of banks, ≥1; `BW = max(1, $clog2(NBANKS))`.
- `NREAD`, 2: number of read ports, ≥1.

- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `ready` out 1: high when the sweep is done and the block accepts reads/writes.
- `readBank` in NREAD*BW: bank select per read port, port p at `[p*BW +: BW]`.
- `readAddr` in NREAD*AW: register index per read port, port p at `[p*AW +: AW]`.
- `readData` out NREAD*XLEN: registered read data, port p at `[p*XLEN +: XLEN]`.
- `writeEnable` in 1: write request.
- `writeBank` in BW: write bank select.
- `writeAddr` in AW: write register index.
- `writeData` in XLEN: write data.

## Operation
- Two states: CLEAR and RUN.
- RESET high puts the block in CLEAR with `sweepIdx=0`, `ready=0`, and all `readData=0`. This applies asynchronously at any time, including mid-sweep or mid-RUN.
- CLEAR: each rising edge writes 0 to entry `sweepIdx` in every bank in parallel, then `sweepIdx++`.
  - On the edge that clears entry NREGS-1, go to RUN and set `ready=1`.
  - `writeEnable` is ignored in CLEAR; `readData` is held at 0.
- RUN: each edge, if `writeEnable` and the target is legal, `bank[writeBank][writeAddr] <= writeData`.
  - Each read port p registers `readData[p] <= value(readBank[p], readAddr[p])`.
- Zero register: bank 0 entry 0 always reads 0, and writes to it are dropped. Entry 0 of banks ≥1 is an ordinary writable register.
- Illegal target: a bank index ≥ NBANKS or an address ≥ NREGS counts as illegal.
  - A write to an illegal target is dropped.
  - A read of an illegal target returns 0.
- Forwarding: if `writeEnable` is high, the write is legal and not to bank0/x0, and a read port addresses the same bank and address in the same cycle, that port registers `writeData`, not the old contents.
- Several read ports may address the same entry; each gets the same value independently.
- The sweep counter is AW+1 bits wide so that NREGS which are not a power of two terminate correctly.

## Timing
- Read latency is 1 cycle. Address and bank presented before edge N appear on `readData` after edge N, and are held until the next edge.
- Write is visible to a non-forwarded read presented in the cycle after the write edge. The same-cycle read gets it through forwarding.
- Sweep length: `ready` rises after exactly NREGS rising edges following RESET deassertion. The first accepted write/read is at edge NREGS+1.
- Reset values: `ready=0`, all `readData=0`, state CLEAR, `sweepIdx=0`. Register array contents are undefined until the sweep completes.
- RESET asserted mid-sweep restarts the sweep from index 0 after deassertion. Entries already cleared stay 0.
- RESET asserted in RUN discards any write in that cycle and re-clears the whole array.

## Test plan
- Reset sweep: default params, pulse RESET, count edges → `ready` goes 1 after exactly 32 edges. Every (bank, addr) then reads 0, and `readData` stays 0 throughout CLEAR.
- Basic write/read: write bank0 x5=0xDEADBEEF and bank1 f5=0x12345678, then read both on ports 0/1 the next cycle → 0xDEADBEEF and 0x12345678 one cycle later. No cross-bank aliasing.
- Zero register: write bank0 x0=0xFFFFFFFF, then read → 0. Write bank1 f0=0xFFFFFFFF, then read → 0xFFFFFFFF.
- Forwarding: same cycle, write bank0 x7=0xA5A5A5A5 while port 0 reads x7 and port 1 reads bank1 f7 → port0=0xA5A5A5A5, port1=old f7 (0). The same-cycle write to x0 is not forwarded (reads 0).
- Writes ignored in CLEAR: hold `writeEnable` with x3=0x55 during the sweep → x3 reads 0 after `ready`.
- Mid-sweep reset and odd params: assert RESET at sweep edge 10 → `ready` at edge 32 after the new deassertion. With NREGS=24, NBANKS=3, NREAD=3: sweep is 24 edges, bank index 3 and addr 24 read 0 and their writes are dropped.
